// File: rtl/re_ram_ctrl_pkg.sv
// Shared types and constants for the ReRAM NVM port arbiter and access sequencer.
package re_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_CORE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; last_grant only moves when an access completes.
module rr_arbiter2
  import re_ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic done,
  input  logic served,
  output logic gnt_valid,
  output logic gnt_port
);

  logic last_grant;

  always_comb begin
    gnt_valid = valid0 | valid1;
    if (valid0 && valid1)
      gnt_port = ~last_grant;
    else if (valid1)
      gnt_port = PORT_CORE;
    else
      gnt_port = PORT_HOST;
  end

  // Reset to the core port so the host wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= PORT_CORE;
    else if (done)
      last_grant <= served;
  end

endmodule

// File: rtl/re_ram_arbiter.sv
// Shares the single ReRAM NVM port between host bridge (port 0) and core weight fetch (port 1),
// sequencing each access through ISSUE/WAIT/DONE with a timeout against a silent NVM.
module re_ram_arbiter
  import re_ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  output logic                  resp0_err,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic                  resp1_err,
  output logic                  nvm_we,
  output logic [ADDR_WIDTH-1:0] nvm_addr,
  output logic [DATA_WIDTH-1:0] nvm_data_in,
  input  logic [DATA_WIDTH-1:0] nvm_data_out,
  input  logic                  nvm_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state;
  logic                  port_q;
  logic                  we_q;
  logic [CW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  gnt_valid;
  logic                  gnt_port;
  logic                  idle;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .done      (state == DONE),
    .served    (port_q),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  assign idle        = (state == IDLE);
  assign req0_ready  = idle && gnt_valid && (gnt_port == PORT_HOST);
  assign req1_ready  = idle && gnt_valid && (gnt_port == PORT_CORE);
  assign resp0_rdata = rdata_q;
  assign resp1_rdata = rdata_q;
  assign resp0_err   = err_q;
  assign resp1_err   = err_q;

  // Response data/error are captured on entry to DONE and held until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      port_q      <= PORT_HOST;
      we_q        <= 1'b0;
      tcnt        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      nvm_we      <= 1'b0;
      nvm_addr    <= '0;
      nvm_data_in <= '0;
    end else begin
      nvm_we      <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            port_q      <= gnt_port;
            we_q        <= gnt_port ? req1_we : req0_we;
            nvm_we      <= gnt_port ? req1_we : req0_we;
            nvm_addr    <= gnt_port ? req1_addr : req0_addr;
            nvm_data_in <= gnt_port ? req1_wdata : req0_wdata;
            tcnt        <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (nvm_ack || tcnt == CW'(TIMEOUT_CYCLES)) begin
            rdata_q     <= (nvm_ack && !we_q) ? nvm_data_out : '0;
            err_q       <= ~nvm_ack;
            resp0_valid <= (port_q == PORT_HOST);
            resp1_valid <= (port_q == PORT_CORE);
            state       <= DONE;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_re_ram_arbiter.sv
// Directed bench for re_ram_arbiter with an NVM model and a response scoreboard.
module tb_re_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 15;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_we, req0_ready, resp0_valid, resp0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, resp0_rdata;
  logic          req1_valid, req1_we, req1_ready, resp1_valid, resp1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, resp1_rdata;
  logic          nvm_we, nvm_ack;
  logic [AW-1:0] nvm_addr;
  logic [DW-1:0] nvm_data_in, nvm_data_out;

  logic          nvm_init;
  logic          ack_en;
  logic [DW-1:0] nvm_mem [256];
  logic [DW-1:0] ref_mem [256];
  exp_t          sb [$];
  logic          hs_ports [$];
  int            hs_cycs [$];
  int            cyc = 0;
  int            hs_cyc = -10;
  logic          hs_we = 1'b0;
  logic [AW-1:0] hs_addr = '0;
  logic [DW-1:0] hs_wdata = '0;
  int            resp1_cnt = 0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  re_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_ready   (req0_ready),
    .resp0_valid  (resp0_valid),
    .resp0_rdata  (resp0_rdata),
    .resp0_err    (resp0_err),
    .req1_valid   (req1_valid),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_ready   (req1_ready),
    .resp1_valid  (resp1_valid),
    .resp1_rdata  (resp1_rdata),
    .resp1_err    (resp1_err),
    .nvm_we       (nvm_we),
    .nvm_addr     (nvm_addr),
    .nvm_data_in  (nvm_data_in),
    .nvm_data_out (nvm_data_out),
    .nvm_ack      (nvm_ack)
  );

  function automatic logic [DW-1:0] pattern(int i);
    return DW'(i) ^ 8'h5C;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkReset(string tag);
    checkOutput({tag, "_req0_ready"}, 32'(req0_ready), 0);
    checkOutput({tag, "_req1_ready"}, 32'(req1_ready), 0);
    checkOutput({tag, "_resp0_valid"}, 32'(resp0_valid), 0);
    checkOutput({tag, "_resp1_valid"}, 32'(resp1_valid), 0);
    checkOutput({tag, "_resp_err"}, 32'({resp0_err, resp1_err}), 0);
    checkOutput({tag, "_resp_rdata"}, 32'({resp0_rdata, resp1_rdata}), 0);
    checkOutput({tag, "_nvm_we"}, 32'(nvm_we), 0);
    checkOutput({tag, "_nvm_addr"}, 32'(nvm_addr), 0);
    checkOutput({tag, "_nvm_data_in"}, 32'(nvm_data_in), 0);
  endtask

  // Drive one request and hold it until the handshake cycle, then release.
  task automatic applyStimulus(logic port, logic we, logic [AW-1:0] addr, logic [DW-1:0] wdata);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (port ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("handshake_seen", 32'(ok), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic waitHandshakes(int target);
    for (int i = 0; i < 60 && hs_ports.size() < target; i++)
      @(posedge clk);
    checkOutput("handshake_count", 32'(hs_ports.size()), 32'(target));
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(string tag, int n);
    repeat (n) @(posedge clk);
    #1;
    checkOutput(tag, 32'(sb.size()), 0);
  endtask

  // NVM model: registered read data one cycle after the address, writes on nvm_we.
  assign nvm_ack = ack_en;
  always @(posedge clk) begin
    if (nvm_init) begin
      for (int i = 0; i < 256; i++) nvm_mem[i] <= pattern(i);
    end else begin
      if (nvm_we) nvm_mem[nvm_addr] <= nvm_data_in;
      nvm_data_out <= nvm_mem[nvm_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: NVM strobe timing, response scoreboard, and expectation push on handshake.
  always @(negedge clk) begin
    exp_t          e;
    logic          p;
    logic          we;
    logic [AW-1:0] a;
    if (nvm_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= pattern(i);
    end else if (!rst) begin
      checkOutput("nvm_we_timing", 32'(nvm_we), 32'((cyc == hs_cyc + 1) && hs_we));
      if (nvm_we) begin
        checkOutput("nvm_addr", 32'(nvm_addr), 32'(hs_addr));
        checkOutput("nvm_data_in", 32'(nvm_data_in), 32'(hs_wdata));
      end
      if (resp1_valid) resp1_cnt <= resp1_cnt + 1;
      if (resp0_valid || resp1_valid) begin
        checkOutput("resp_onehot", 32'(resp0_valid && resp1_valid), 0);
        checkOutput("resp_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("resp_port", 32'(resp1_valid), 32'(e.port));
          checkOutput("resp_rdata", 32'(resp1_valid ? resp1_rdata : resp0_rdata), 32'(e.rdata));
          checkOutput("resp_err", 32'(resp1_valid ? resp1_err : resp0_err), 32'(e.err));
          checkOutput("resp_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        checkOutput("ready_onehot", 32'(req0_ready && req1_ready), 0);
        p  = req1_valid && req1_ready;
        we = p ? req1_we : req0_we;
        a  = p ? req1_addr : req0_addr;
        e.port  = p;
        e.rdata = (we || !ack_en) ? '0 : ref_mem[a];
        e.err   = ~ack_en;
        e.due   = cyc + (ack_en ? 3 : 3 + TO);
        sb.push_back(e);
        if (we) ref_mem[a] <= p ? req1_wdata : req0_wdata;
        hs_cyc   <= cyc;
        hs_we    <= we;
        hs_addr  <= a;
        hs_wdata <= p ? req1_wdata : req0_wdata;
        hs_ports.push_back(p);
        hs_cycs.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    int r1;
    rst = 1'b1; nvm_init = 1'b1; ack_en = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    nvm_init = 1'b0;
    rst = 1'b0;

    $display("[TB] host write 0x12 <- 0xA5, then core read back");
    applyStimulus(1'b0, 1'b1, 8'h12, 8'hA5);
    drain("drain_write", 6);
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h00);
    drain("drain_read", 6);

    $display("[TB] continuous contention, alternating grants");
    s = hs_ports.size();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h01;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h02;
    waitHandshakes(s + 4);
    if (hs_ports.size() >= s + 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("contention_grant", 32'(hs_ports[s + k]), 32'(k % 2));
        if (k > 0) checkOutput("contention_spacing", 32'(hs_cycs[s + k] - hs_cycs[s + k - 1]), 4);
      end
    end
    drain("drain_contention", 6);

    $display("[TB] timeout with nvm_ack held low");
    ack_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h30, 8'h00);
    drain("drain_timeout", 22);
    ack_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h12, 8'h00);
    drain("drain_after_timeout", 6);

    $display("[TB] reset during WAIT of a core read");
    ack_en = 1'b0;
    r1 = resp1_cnt;
    applyStimulus(1'b1, 1'b0, 8'h02, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkReset("midreset");
    sb.delete();
    ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("no_resp1_after_abort", 32'(resp1_cnt), 32'(r1));
    s = hs_ports.size();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h01;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h02;
    waitHandshakes(s + 2);
    if (hs_ports.size() >= s + 2) begin
      checkOutput("post_reset_first", 32'(hs_ports[s]), 0);
      checkOutput("post_reset_second", 32'(hs_ports[s + 1]), 1);
    end
    drain("drain_post_reset", 6);

    $display("[TB] host request raised while busy");
    applyStimulus(1'b1, 1'b0, 8'h02, 8'h00);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("busy_ready0", 32'(req0_ready), 0);
    end
    @(negedge clk);
    checkOutput("idle_ready0", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain("drain_busy", 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
